// File: rtl/mux_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_decode_pkg
// Brief    : Parameter legality limits and select-width helper for mux_decode_pipe.
// Revision : 1.0
// ============================================================================
package mux_decode_pkg;

  localparam int CH_MAX = 16;
  localparam int W_MAX  = 6;

  // Select width for a given channel count; never narrower than one bit.
  function automatic int calc_sw(input int ch);
    return (ch < 2) ? 1 : $clog2(ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdp_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mdp_decoder
// Brief    : Combinational one-hot decode of a W-bit code plus half-XOR reductions.
// Revision : 1.0
// ============================================================================
module mdp_decoder
  import mux_decode_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]      code,
  output logic [2**W-1:0]   onehot,
  output logic              xor_lo,
  output logic              xor_hi
);

  localparam int c_n_codes = 2**W;
  localparam int c_half    = 2**(W-1);

  if (W < 1 || W > W_MAX) begin : g_param_check
    $error("mdp_decoder: W out of range");
  end

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

  assign xor_lo = ^onehot[c_half-1:0];
  assign xor_hi = ^onehot[c_n_codes-1:c_half];

endmodule
`default_nettype wire

// File: rtl/mux_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_decode_pipe
// Brief    : Two-stage valid/ready channel mux + one-hot decode with optional
//            per-code hit counters (enabled by macro MUX_DECODE_HIT_CNT_EN).
// Revision : 1.0
// ============================================================================
module mux_decode_pipe
  import mux_decode_pkg::*;
#(
  parameter int CH    = 2,
  parameter int W     = 2,
  parameter int CNT_W = 8,
  parameter int SW    = calc_sw(CH)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*W-1:0]     ch_data,
  input  logic [SW-1:0]       sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        code,
  output logic [2**W-1:0]     onehot,
  output logic                xor_lo,
  output logic                xor_hi,
  output logic                sel_err,
  input  logic [W-1:0]        cnt_idx,
  output logic [CNT_W-1:0]    cnt_rd,
  input  logic                cnt_clr
);

  if (CH < 2 || CH > CH_MAX || W < 1 || W > W_MAX) begin : g_param_check
    $error("mux_decode_pipe: CH or W out of range");
  end

  logic               r_s1_valid;
  logic [W-1:0]       r_s1_code;
  logic               r_s1_err;
  logic               r_s2_valid;
  logic [W-1:0]       r_code;
  logic [2**W-1:0]    r_onehot;
  logic               r_xor_lo;
  logic               r_xor_hi;
  logic               r_sel_err;

  logic [W-1:0]       w_mux_code;
  logic               w_sel_err;
  logic               w_s1_load;
  logic               w_s2_load;
  logic [2**W-1:0]    w_dec_onehot;
  logic               w_dec_xor_lo;
  logic               w_dec_xor_hi;

  // Out-of-range selects match no channel, so the code falls back to zero.
  always_comb begin
    w_mux_code = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SW'(k)) w_mux_code = ch_data[k*W +: W];
    end
  end

  assign w_sel_err = ({1'b0, sel} >= (SW+1)'(CH));

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code <= w_mux_code;
        r_s1_err  <= w_sel_err;
      end
    end
  end

  mdp_decoder #(.W(W)) u_decoder (
    .code   (r_s1_code),
    .onehot (w_dec_onehot),
    .xor_lo (w_dec_xor_lo),
    .xor_hi (w_dec_xor_hi)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s2_valid <= 1'b0;
      r_code     <= '0;
      r_onehot   <= '0;
      r_xor_lo   <= 1'b0;
      r_xor_hi   <= 1'b0;
      r_sel_err  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_code    <= r_s1_code;
        r_onehot  <= w_dec_onehot;
        r_xor_lo  <= w_dec_xor_lo;
        r_xor_hi  <= w_dec_xor_hi;
        r_sel_err <= r_s1_err;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign code      = r_code;
  assign onehot    = r_onehot;
  assign xor_lo    = r_xor_lo;
  assign xor_hi    = r_xor_hi;
  assign sel_err   = r_sel_err;

`ifdef MUX_DECODE_HIT_CNT_EN
  logic               w_out_xfer;
  logic [CNT_W-1:0]   r_hit_cnt [2**W];

  assign w_out_xfer = r_s2_valid && out_ready;

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2**W; i++) r_hit_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 2**W; i++) r_hit_cnt[i] <= '0;
    end else if (w_out_xfer && (r_hit_cnt[r_code] != '1)) begin
      r_hit_cnt[r_code] <= r_hit_cnt[r_code] + CNT_W'(1);
    end
  end

  assign cnt_rd = r_hit_cnt[cnt_idx];
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^{cnt_clr, cnt_idx};
  assign cnt_rd       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_decode_pipe
// Brief    : Scoreboard bench for mux_decode_pipe (CH=3, W=2, CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_mux_decode_pipe;

  localparam int c_ch    = 3;
  localparam int c_w     = 2;
  localparam int c_cnt_w = 2;
`ifdef MUX_DECODE_HIT_CNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  ch_data;
  logic [1:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  code;
  logic [3:0]  onehot;
  logic        xor_lo;
  logic        xor_hi;
  logic        sel_err;
  logic [1:0]  cnt_idx;
  logic [1:0]  cnt_rd;
  logic        cnt_clr;

  always #5 Clock = ~Clock;

  mux_decode_pipe #(.CH(c_ch), .W(c_w), .CNT_W(c_cnt_w)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ch_data(ch_data), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .code(code), .onehot(onehot), .xor_lo(xor_lo), .xor_hi(xor_hi),
    .sel_err(sel_err), .cnt_idx(cnt_idx), .cnt_rd(cnt_rd), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [1:0] code;
    logic [3:0] oh;
    logic       xl;
    logic       xh;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   n_xfer  = 0;
  bit   chk_lat = 1'b0;
  bit   last_acc;
  int   m_cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [5:0] d, input logic [1:0] s);
    exp_t e;
    e.err  = (int'(s) >= c_ch);
    e.code = e.err ? 2'd0 : 2'((d >> (2 * int'(s))) & 6'd3);
    e.oh   = 4'b0001 << e.code;
    e.xl   = (e.code < 2'd2);
    e.xh   = (e.code >= 2'd2);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Sample just before the rising edge, then return on the following falling edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    bit   xfer;
    #4;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e = model(ch_data, sel);
      e.cyc = cyc;
      q.push_back(e);
    end
    xfer = out_valid && out_ready;
    if (xfer) begin
      n_xfer++;
      if (q.size() == 0) begin
        check("stale", 32'(out_valid), 32'd0);
      end else begin
        g = q.pop_front();
        check("code",    32'(code),    32'(g.code));
        check("onehot",  32'(onehot),  32'(g.oh));
        check("xor_lo",  32'(xor_lo),  32'(g.xl));
        check("xor_hi",  32'(xor_hi),  32'(g.xh));
        check("sel_err", 32'(sel_err), 32'(g.err));
        if (chk_lat) check("latency", 32'(cyc - g.cyc), 32'd2);
        if (!cnt_clr && m_cnt[g.code] < 3) m_cnt[g.code]++;
      end
    end
    if (cnt_clr) clr_model();
    @(posedge Clock);
    cyc++;
    @(negedge Clock);
  endtask

  task automatic cnt_check(input string tag);
    check(tag, 32'(cnt_rd), c_cnt_en ? 32'(m_cnt[cnt_idx]) : 32'd0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s_code;
    logic [3:0] s_oh;
    logic       s_err;
    bit         have_snap;
    int         b;
    int         x0;

    Reset_n = 1'b0; in_valid = 1'b0; ch_data = '0; sel = '0;
    out_ready = 1'b1; cnt_idx = 2'd1; cnt_clr = 1'b0;
    clr_model();
    @(negedge Clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_onehot",    32'(onehot),    32'd0);
    check("rst_sel_err",   32'(sel_err),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_cnt",       32'(cnt_rd),    32'd0);
    Reset_n = 1'b1;
    tick();

    // Basic beats with latency checking
    chk_lat  = 1'b1;
    in_valid = 1'b1; sel = 2'd0; ch_data = 6'b01_11_00;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk_lat = 1'b0;
    check("basic_q", 32'(q.size()), 32'd0);

    // Out-of-range select, then the last legal channel
    in_valid = 1'b1; sel = 2'd3; ch_data = 6'b10_11_11;
    tick();
    sel = 2'd2;
    tick();
    drain();

    // Random stream with random backpressure
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      ch_data   = 6'($urandom);
      tick();
    end
    drain();

    // Stall: 3 beats offered while downstream is blocked for 5 cycles
    x0 = n_xfer; b = 0; have_snap = 1'b0;
    out_ready = 1'b0; ch_data = 6'b11_10_01;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = 2'(b);
      tick();
      if (last_acc) b++;
      if (out_valid) begin
        if (!have_snap) begin
          s_code = code; s_oh = onehot; s_err = sel_err; have_snap = 1'b1;
        end else begin
          check("hold_code",   32'(code),    32'(s_code));
          check("hold_onehot", 32'(onehot),  32'(s_oh));
          check("hold_err",    32'(sel_err), 32'(s_err));
        end
      end
    end
    check("stall_accepted", 32'(b), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && b < 3; i++) begin
      in_valid = 1'b1; sel = 2'(b);
      tick();
      if (last_acc) b++;
    end
    drain();
    check("stall_beats_out", 32'(n_xfer - x0), 32'd3);

    // Hit counters: saturation, then clear concurrent with a transfer
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cnt_check("cnt_cleared");
    in_valid = 1'b1; sel = 2'd0; ch_data = 6'b00_00_01;
    repeat (5) tick();
    drain();
    cnt_idx = 2'd1;
    cnt_check("cnt_sat");
    cnt_idx = 2'd0;
    cnt_check("cnt_other");
    cnt_idx = 2'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check("cnt_beat_ready", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    cnt_check("cnt_clr_xfer");

    // Asynchronous reset with two beats in flight
    in_valid = 1'b1; sel = 2'd1; ch_data = 6'b00_10_00;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_onehot",    32'(onehot),    32'd0);
    check("arst_cnt",       32'(cnt_rd),    32'd0);
    q.delete();
    clr_model();
    @(negedge Clock);
    Reset_n = 1'b1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    x0 = n_xfer;
    repeat (5) tick();
    check("arst_no_stale", 32'(n_xfer - x0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
